avalon_mm_csr_bank: RTL and testbench
=====================================

// Module: avalon_mm_csr_bank
// PURPOSE
//  Parametrised Avalon-MM slave register bank that serves as the host-facing CSR block for
//  accelerator cores such as AES decrypt. It adds these features:
//  - arbitrary byte-lane write masking
//  - registered reads with READDATAVALID
//  - a core-owned read-only result window
//  - a START pulse generator
//  - a sticky DONE flag with write-1-to-clear
// PARAMETERS
//  DATA_W     32  data width in bits; multiple of 8
//  NUM_REGS   16  number of registers
//  ADDR_W     4   address width; NUM_REGS <= 2**ADDR_W
//  RO_BASE    8   first index of the core-written, host-read-only window
//  RO_COUNT   4   number of registers in the RO window
//  START_IDX  14  index of the START register
//  DONE_IDX   15  index of the DONE register
// PORTS
//  Clk                i  1                 clock
//  Reset              i  1                 synchronous, active-high
//  AVL_READ           i  1                 read request
//  AVL_WRITE          i  1                 write request
//  AVL_CS             i  1                 chip select; qualifies READ and WRITE
//  AVL_BYTE_EN        i  DATA_W/8          byte-lane enables for writes
//  AVL_ADDR           i  ADDR_W            register index
//  AVL_WRITEDATA      i  DATA_W            write data
//  AVL_READDATA       o  DATA_W            registered read data
//  AVL_READDATAVALID  o  1                 AVL_READDATA valid this cycle
//  CORE_START         o  1                 one-cycle start pulse to the core
//  CORE_DONE          i  1                 core completion pulse
//  CORE_RES_WE        i  1                 core result write enable
//  CORE_RES_IDX       i  ADDR_W            core result target index (absolute)
//  CORE_RES_DATA      i  DATA_W            core result data (full word)
//  REG_Q              o  NUM_REGS*DATA_W   flattened register contents; reg i at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset
//  - Reset (synchronous, active-high) on Clk clears every register to 0.
//  - It also clears AVL_READDATA, AVL_READDATAVALID, CORE_START and the START edge-detect history.
//  - Reset overrides all same-cycle writes and events.
//  Host write
//  - Accepted when AVL_CS & AVL_WRITE; takes effect at the next Clk edge.
//  - Byte lane b is updated iff AVL_BYTE_EN[b]; lanes with enable 0 hold their value.
//  - Any enable pattern is legal, including non-contiguous patterns; all-zero is a no-op.
//  - Writes are ignored when the address is >= NUM_REGS or falls in [RO_BASE, RO_BASE+RO_COUNT).
//  Host read
//  - Sampled when AVL_CS & AVL_READ.
//  - One cycle later: AVL_READDATA holds the register value as it was before that edge's writes,
//    and AVL_READDATAVALID=1 for exactly one cycle.
//  - Back-to-back reads give one valid cycle per request, with no gaps.
//  - Out-of-range address returns 0.
//  - AVL_READDATA holds its last value while AVL_READDATAVALID=0.
//  - If READ and WRITE are asserted in the same cycle, both are performed and the read returns
//    the pre-write value.
//  Core result port
//  - When CORE_RES_WE=1 and CORE_RES_IDX is in the RO window, the full word is written.
//  - Otherwise the core write is ignored.
//  START register
//  - Normal read/write register.
//  - CORE_START pulses high for exactly one cycle, in the cycle after bit0 of START goes 0->1.
//  - Rewriting 1 while bit0 is already 1 produces no pulse; software writes 0 then 1 to restart.
//  DONE register (bit0 only; other bits read 0)
//  - Set to 1 on CORE_DONE.
//  - Cleared on a host write to DONE_IDX with byte lane 0 enabled and WRITEDATA[0]=1 (W1C).
//  - Also cleared on any host write that sets START bit0 0->1.
//  - Set and clear in the same cycle: set wins.
//  - CORE_DONE held for multiple cycles has the same effect as a single pulse.
// TESTING
//  - Reset, then read every index -> READDATAVALID one cycle after each READ; all data 0; CORE_START 0.
//  - Write 0xDEADBEEF to idx 0 with BYTE_EN=1111, then 0x11223344 with BYTE_EN=0101
//    -> read returns 0xDE22BE44.
//  - Write 0xFFFFFFFF to idx 9, then CORE_RES_WE idx 9 with 0xCAFEF00D
//    -> read returns 0xCAFEF00D; a core write to idx 3 leaves idx 3 unchanged.
//  - Write START=1 -> one CORE_START pulse; write 1 again -> no pulse;
//    write 0 then 1 -> second pulse; DONE cleared on each 0->1.
//  - CORE_DONE pulse -> DONE reads 1; W1C to DONE in the same cycle as CORE_DONE -> DONE stays 1;
//    W1C alone -> 0.
//  - Assert Reset mid-sequence with a read outstanding -> next cycle READDATAVALID=0,
//    CORE_START=0, all registers 0.

Source files
------------

// File: rtl/avalon_mm_csr_bank.sv
// avalon_mm_csr_bank
// Host-facing Avalon-MM control/status register bank for an accelerator core.
// The host reads and writes the registers with per-byte write enables, and read data
// comes back one cycle later with a valid strobe. A window of registers is written only
// by the core and is read-only to the host. Bit 0 of START produces a one-cycle start
// pulse to the core. DONE is a sticky flag that the core sets; the host clears it by
// writing 1 to it, or by starting the core again.
//
// Ports
//   Clk, Reset                  clock; synchronous active-high reset
//   AVL_CS/READ/WRITE           host request qualifiers (CS gates READ and WRITE)
//   AVL_ADDR, AVL_BYTE_EN       register index and byte-lane enables for writes
//   AVL_WRITEDATA               host write data
//   AVL_READDATA(VALID)         registered read response, one cycle after the request
//   CORE_START                  one-cycle start pulse to the core
//   CORE_DONE                   core completion event; sets DONE
//   CORE_RES_WE/IDX/DATA        core full-word writes into the read-only window
//   REG_Q                       flattened register contents, reg i at [i*DATA_W +: DATA_W]

module avalon_mm_csr_bank #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned RO_BASE   = 8,
    parameter int unsigned RO_COUNT  = 4,
    parameter int unsigned START_IDX = 14,
    parameter int unsigned DONE_IDX  = 15
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         AVL_READ,
    input  logic                         AVL_WRITE,
    input  logic                         AVL_CS,
    input  logic [DATA_W/8-1:0]          AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]            AVL_ADDR,
    input  logic [DATA_W-1:0]            AVL_WRITEDATA,
    output logic [DATA_W-1:0]            AVL_READDATA,
    output logic                         AVL_READDATAVALID,
    output logic                         CORE_START,
    input  logic                         CORE_DONE,
    input  logic                         CORE_RES_WE,
    input  logic [ADDR_W-1:0]            CORE_RES_IDX,
    input  logic [DATA_W-1:0]            CORE_RES_DATA,
    output logic [NUM_REGS*DATA_W-1:0]   REG_Q
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned RO_END  = RO_BASE + RO_COUNT;
    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_IDX);
    localparam logic [ADDR_W-1:0] DONE_A  = ADDR_W'(DONE_IDX);

    // Register storage and response/pulse state
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              rvalid_q;
    logic              rvalid_d;
    logic              start_hist_q;
    logic              start_hist_d;
    logic              core_start_q;
    logic              core_start_d;

    // Decoded request terms
    logic              host_wr_c;
    logic              host_rd_c;
    logic              wr_ok_c;
    logic              core_wr_ok_c;
    logic              start_set_c;
    logic              done_w1c_c;
    logic              done_d;
    logic [DATA_W-1:0] rd_data_c;

    function automatic logic idx_in_range(input logic [ADDR_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    function automatic logic idx_in_ro(input logic [ADDR_W-1:0] idx);
        return (32'(idx) >= RO_BASE) && (32'(idx) < RO_END);
    endfunction

    // Request qualification and DONE/START side effects
    always_comb begin
        host_wr_c    = AVL_CS & AVL_WRITE;
        host_rd_c    = AVL_CS & AVL_READ;
        wr_ok_c      = host_wr_c & idx_in_range(AVL_ADDR) & ~idx_in_ro(AVL_ADDR);
        core_wr_ok_c = CORE_RES_WE & idx_in_ro(CORE_RES_IDX);

        // A write that raises START bit0 re-arms the core, so it also clears DONE
        start_set_c  = wr_ok_c & (AVL_ADDR == START_A) & AVL_BYTE_EN[0]
                     & AVL_WRITEDATA[0] & ~regs_q[START_IDX][0];
        done_w1c_c   = wr_ok_c & (AVL_ADDR == DONE_A) & AVL_BYTE_EN[0]
                     & AVL_WRITEDATA[0];

        // Set beats clear; a held CORE_DONE just keeps setting the same bit
        done_d       = CORE_DONE | (regs_q[DONE_IDX][0] & ~(done_w1c_c | start_set_c));
    end

    // Next register values: host byte writes, core window writes, DONE flag
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (i == DONE_IDX) begin
                regs_d[i] = {{(DATA_W-1){1'b0}}, done_d};
            end else if ((i >= RO_BASE) && (i < RO_END)) begin
                if (core_wr_ok_c && (CORE_RES_IDX == ADDR_W'(i))) begin
                    regs_d[i] = CORE_RES_DATA;
                end
            end else if (wr_ok_c && (AVL_ADDR == ADDR_W'(i))) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (AVL_BYTE_EN[b]) begin
                        regs_d[i][b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read mux over the pre-write contents; indices with no register return 0
    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (AVL_ADDR == ADDR_W'(i)) begin
                rd_data_c = regs_q[i];
            end
        end
    end

    // Read response and START edge detection
    always_comb begin
        rvalid_d     = host_rd_c;
        rdata_d      = host_rd_c ? rd_data_c : rdata_q;
        // Pulse lands the cycle after bit0 is first seen high
        start_hist_d = regs_q[START_IDX][0];
        core_start_d = regs_q[START_IDX][0] & ~start_hist_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            start_hist_q <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            start_hist_q <= start_hist_d;
            core_start_q <= core_start_d;
        end
    end

    // Output mapping
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            REG_Q[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign AVL_READDATA      = rdata_q;
    assign AVL_READDATAVALID = rvalid_q;
    assign CORE_START        = core_start_q;

endmodule

// File: tb/tb_avalon_mm_csr_bank.sv
// tb_avalon_mm_csr_bank
// Self-checking bench for avalon_mm_csr_bank: directed feature scenarios plus a
// randomized run, all compared against a behavioural model of the register bank.

module tb_avalon_mm_csr_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned NR    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned ROB   = 8;
    localparam int unsigned ROC   = 4;
    localparam int unsigned SIDX  = 14;
    localparam int unsigned DIDX  = 15;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              AVL_READ;
    logic              AVL_WRITE;
    logic              AVL_CS;
    logic [DW/8-1:0]   AVL_BYTE_EN;
    logic [AW-1:0]     AVL_ADDR;
    logic [DW-1:0]     AVL_WRITEDATA;
    logic [DW-1:0]     AVL_READDATA;
    logic              AVL_READDATAVALID;
    logic              CORE_START;
    logic              CORE_DONE;
    logic              CORE_RES_WE;
    logic [AW-1:0]     CORE_RES_IDX;
    logic [DW-1:0]     CORE_RES_DATA;
    logic [NR*DW-1:0]  REG_Q;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_rdata;
    logic          m_rvalid;
    logic          m_start;
    logic          m_prev_bit;

    avalon_mm_csr_bank #(
        .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .RO_BASE(ROB),
        .RO_COUNT(ROC), .START_IDX(SIDX), .DONE_IDX(DIDX)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
        .CORE_START(CORE_START), .CORE_DONE(CORE_DONE),
        .CORE_RES_WE(CORE_RES_WE), .CORE_RES_IDX(CORE_RES_IDX),
        .CORE_RES_DATA(CORE_RES_DATA), .REG_Q(REG_Q)
    );

    always #5 Clk = ~Clk;

    function automatic logic is_ro(input int unsigned idx);
        return (idx >= ROB) && (idx < ROB + ROC);
    endfunction

    function automatic logic [DW-1:0] dut_reg(input int unsigned idx);
        return REG_Q[idx*DW +: DW];
    endfunction

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
        return f;
    endfunction

    // Applies one clock edge of the register-bank rules to the model
    task automatic model_step();
        logic [DW-1:0] nw;
        logic          clr;
        logic          d;
        int unsigned   a;
        int unsigned   ci;
        a  = 32'(AVL_ADDR);
        ci = 32'(CORE_RES_IDX);
        if (Reset) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_rdata    = '0;
            m_rvalid   = 1'b0;
            m_start    = 1'b0;
            m_prev_bit = 1'b0;
            return;
        end
        m_rvalid = AVL_CS && AVL_READ;
        if (m_rvalid) m_rdata = (a < NR) ? m_regs[a] : '0;
        m_start    = m_regs[SIDX][0] && !m_prev_bit;
        m_prev_bit = m_regs[SIDX][0];
        clr = 1'b0;
        if (AVL_CS && AVL_WRITE && a < NR && !is_ro(a)) begin
            if (a == DIDX) begin
                clr = AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
            end else begin
                nw = m_regs[a];
                for (int b = 0; b < DW/8; b++)
                    if (AVL_BYTE_EN[b]) nw[b*8 +: 8] = AVL_WRITEDATA[b*8 +: 8];
                if (a == SIDX && !m_regs[SIDX][0] && nw[0]) clr = 1'b1;
                m_regs[a] = nw;
            end
        end
        if (CORE_RES_WE && is_ro(ci)) m_regs[ci] = CORE_RES_DATA;
        d = (m_regs[DIDX][0] && !clr) || CORE_DONE;
        m_regs[DIDX] = {{(DW-1){1'b0}}, d};
    endtask

    task automatic idle();
        Reset = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
        AVL_BYTE_EN = '0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
        CORE_DONE = 1'b0; CORE_RES_WE = 1'b0; CORE_RES_IDX = '0; CORE_RES_DATA = '0;
    endtask

    // Advance one clock with the currently driven inputs, then return to idle
    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        idle();
    endtask

    task automatic wr(input int unsigned a, input logic [DW-1:0] d, input logic [3:0] be);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(a);
        AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    endtask

    task automatic rd(input int unsigned a);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = AW'(a);
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1; tick();
        Reset = 1'b1; tick();
        total++; if (AVL_READDATAVALID !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", AVL_READDATAVALID); end
        total++; if (CORE_START !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", CORE_START); end
        total++; if (REG_Q !== '0) begin bad++; $display("FAIL reset_regq got=%h exp=0", REG_Q); end
        for (int i = 0; i < NR; i++) begin
            rd(i); tick();
            total++;
            if (AVL_READDATAVALID !== 1'b1 || AVL_READDATA !== 32'h0 || CORE_START !== 1'b0) begin
                bad++;
                $display("FAIL reset_read idx=%0d valid=%b data=%h start=%b exp valid=1 data=0 start=0",
                         i, AVL_READDATAVALID, AVL_READDATA, CORE_START);
            end
        end
    endtask

    task automatic test_byte_enable();
        wr(0, 32'hDEADBEEF, 4'b1111); tick();
        wr(0, 32'h11223344, 4'b0101); tick();
        rd(0); tick();
        total++; if (AVL_READDATAVALID !== 1'b1 || AVL_READDATA !== 32'hDE22BE44) begin
            bad++; $display("FAIL byte_en_0101 got=%h v=%b exp=de22be44", AVL_READDATA, AVL_READDATAVALID); end
        wr(1, 32'hAABBCCDD, 4'b1111); tick();
        wr(1, 32'h55667788, 4'b1010); tick();
        wr(1, 32'h99999999, 4'b0000); tick();
        rd(1); tick();
        total++; if (AVL_READDATA !== 32'h55BB77DD) begin
            bad++; $display("FAIL byte_en_1010_then_0000 got=%h exp=55bb77dd", AVL_READDATA); end
    endtask

    task automatic test_core_result();
        wr(9, 32'hFFFFFFFF, 4'b1111); tick();
        total++; if (dut_reg(9) !== 32'h0) begin
            bad++; $display("FAIL ro_host_write got=%h exp=0", dut_reg(9)); end
        CORE_RES_WE = 1'b1; CORE_RES_IDX = 4'd9; CORE_RES_DATA = 32'hCAFEF00D; tick();
        rd(9); tick();
        total++; if (AVL_READDATA !== 32'hCAFEF00D) begin
            bad++; $display("FAIL core_write_ro got=%h exp=cafef00d", AVL_READDATA); end
        wr(3, 32'h12345678, 4'b1111); tick();
        CORE_RES_WE = 1'b1; CORE_RES_IDX = 4'd3; CORE_RES_DATA = 32'h0BAD0BAD; tick();
        rd(3); tick();
        total++; if (AVL_READDATA !== 32'h12345678) begin
            bad++; $display("FAIL core_write_outside got=%h exp=12345678", AVL_READDATA); end
    endtask

    task automatic test_start();
        wr(SIDX, 32'h0, 4'b1111); tick(); tick(); tick();
        CORE_DONE = 1'b1; tick();
        wr(SIDX, 32'h1, 4'b0001); tick();
        total++; if (CORE_START !== 1'b0 || dut_reg(DIDX) !== 32'h0) begin
            bad++; $display("FAIL start_first_edge start=%b done=%h exp start=0 done=0", CORE_START, dut_reg(DIDX)); end
        tick();
        total++; if (CORE_START !== 1'b1) begin bad++; $display("FAIL start_pulse1 got=%b exp=1", CORE_START); end
        tick();
        total++; if (CORE_START !== 1'b0) begin bad++; $display("FAIL start_pulse1_width got=%b exp=0", CORE_START); end
        CORE_DONE = 1'b1; tick();
        wr(SIDX, 32'h1, 4'b0001); tick();
        for (int k = 0; k < 3; k++) begin
            total++; if (CORE_START !== 1'b0) begin bad++; $display("FAIL start_rewrite k=%0d got=%b exp=0", k, CORE_START); end
            tick();
        end
        total++; if (dut_reg(DIDX) !== 32'h1) begin
            bad++; $display("FAIL start_rewrite_done got=%h exp=1", dut_reg(DIDX)); end
        wr(SIDX, 32'h0, 4'b0001); tick();
        wr(SIDX, 32'h1, 4'b0001); tick();
        total++; if (dut_reg(DIDX) !== 32'h0) begin
            bad++; $display("FAIL start_restart_done got=%h exp=0", dut_reg(DIDX)); end
        tick();
        total++; if (CORE_START !== 1'b1) begin bad++; $display("FAIL start_pulse2 got=%b exp=1", CORE_START); end
        tick();
        total++; if (CORE_START !== 1'b0) begin bad++; $display("FAIL start_pulse2_width got=%b exp=0", CORE_START); end
    endtask

    task automatic test_done();
        logic [DW-1:0] exp_seq [6];
        exp_seq = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1};
        for (int s = 0; s < 6; s++) begin
            case (s)
                0: begin CORE_DONE = 1'b1; tick(); end
                1: begin wr(DIDX, 32'h1, 4'b0001); CORE_DONE = 1'b1; tick(); end
                2: begin wr(DIDX, 32'h1, 4'b0001); tick(); end
                3: begin wr(DIDX, 32'hFFFFFFFE, 4'b1111); tick(); end
                4: begin for (int k = 0; k < 3; k++) begin CORE_DONE = 1'b1; tick(); end end
                default: begin wr(DIDX, 32'h1, 4'b1110); tick(); end
            endcase
            rd(DIDX); tick();
            total++; if (AVL_READDATA !== exp_seq[s] || AVL_READDATAVALID !== 1'b1) begin
                bad++; $display("FAIL done_step%0d got=%h v=%b exp=%h", s, AVL_READDATA, AVL_READDATAVALID, exp_seq[s]); end
        end
        wr(DIDX, 32'h1, 4'b0001); tick();
        total++; if (dut_reg(DIDX) !== 32'h0) begin
            bad++; $display("FAIL done_w1c_final got=%h exp=0", dut_reg(DIDX)); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = $urandom;
            wr(4 + i, vals[i], 4'b1111); tick();
        end
        for (int i = 0; i < 4; i++) begin
            rd(4 + i); tick();
            total++; if (AVL_READDATAVALID !== 1'b1 || AVL_READDATA !== vals[i]) begin
                bad++; $display("FAIL b2b_read%0d got=%h v=%b exp=%h", i, AVL_READDATA, AVL_READDATAVALID, vals[i]); end
        end
        wr(5, ~vals[1], 4'b1111); rd(5); tick();
        total++; if (AVL_READDATAVALID !== 1'b1 || AVL_READDATA !== vals[1]) begin
            bad++; $display("FAIL rw_same_cycle got=%h exp=%h", AVL_READDATA, vals[1]); end
        rd(5); tick();
        total++; if (AVL_READDATA !== ~vals[1]) begin
            bad++; $display("FAIL rw_after got=%h exp=%h", AVL_READDATA, ~vals[1]); end
        tick();
        total++; if (AVL_READDATAVALID !== 1'b0 || AVL_READDATA !== ~vals[1]) begin
            bad++; $display("FAIL rdata_hold got=%h v=%b exp=%h v=0", AVL_READDATA, AVL_READDATAVALID, ~vals[1]); end
        AVL_READ = 1'b1; AVL_ADDR = 4'd4; tick();
        total++; if (AVL_READDATAVALID !== 1'b0) begin
            bad++; $display("FAIL read_without_cs got=%b exp=0", AVL_READDATAVALID); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            Reset         = ($urandom_range(0, 63) == 0);
            AVL_CS        = ($urandom_range(0, 7) != 0);
            AVL_READ      = $urandom_range(0, 1) != 0;
            AVL_WRITE     = $urandom_range(0, 1) != 0;
            AVL_ADDR      = ($urandom_range(0, 3) == 0) ? AW'(SIDX + $urandom_range(0, 1)) : AW'($urandom);
            AVL_BYTE_EN   = 4'($urandom);
            AVL_WRITEDATA = $urandom;
            CORE_DONE     = ($urandom_range(0, 7) == 0);
            CORE_RES_WE   = ($urandom_range(0, 3) == 0);
            CORE_RES_IDX  = AW'($urandom);
            CORE_RES_DATA = $urandom;
            tick();
            total++; if (AVL_READDATAVALID !== m_rvalid) begin
                bad++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, AVL_READDATAVALID, m_rvalid); end
            total++; if (AVL_READDATA !== m_rdata) begin
                bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, AVL_READDATA, m_rdata); end
            total++; if (CORE_START !== m_start) begin
                bad++; $display("FAIL rnd_start n=%0d got=%b exp=%b", n, CORE_START, m_start); end
            total++; if (REG_Q !== model_flat()) begin
                bad++; $display("FAIL rnd_regq n=%0d got=%h exp=%h", n, REG_Q, model_flat()); end
        end
    endtask

    task automatic test_reset_mid();
        wr(2, 32'hA5A5A5A5, 4'b1111); tick();
        wr(SIDX, 32'h0, 4'b0001); tick(); tick();
        wr(SIDX, 32'h1, 4'b0001); rd(2); tick();
        total++; if (AVL_READDATAVALID !== 1'b1) begin
            bad++; $display("FAIL mid_pre_valid got=%b exp=1", AVL_READDATAVALID); end
        Reset = 1'b1; rd(2); tick();
        total++; if (AVL_READDATAVALID !== 1'b0 || CORE_START !== 1'b0) begin
            bad++; $display("FAIL mid_reset_ctl v=%b start=%b exp 0 0", AVL_READDATAVALID, CORE_START); end
        total++; if (REG_Q !== '0 || AVL_READDATA !== 32'h0) begin
            bad++; $display("FAIL mid_reset_regs regq=%h rdata=%h exp 0", REG_Q, AVL_READDATA); end
        tick();
        total++; if (CORE_START !== 1'b0 || AVL_READDATAVALID !== 1'b0) begin
            bad++; $display("FAIL mid_after start=%b v=%b exp 0 0", CORE_START, AVL_READDATAVALID); end
    endtask

    initial begin
        idle();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_rdata = '0; m_rvalid = 1'b0; m_start = 1'b0; m_prev_bit = 1'b0;
        test_reset();
        test_byte_enable();
        test_core_result();
        test_start();
        test_done();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
